uart_rx_basic: RTL and testbench

//  Receives 8N1 UART frames (1 start, 8 data LSB-first, 1 stop, no parity) from an async serial line.

---
 rtl/uart_rx_basic.sv | 122 ++++++++++++
 tb/tb_uart_rx_basic.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_basic.sv
// 8N1 UART receiver: two-flop input synchroniser, centre-sampling FSM,
// one-cycle good-byte strobe and one-cycle framing-error strobe.
module uart_rx_basic #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   // State is readable as r_State for debug; IDLE is encoded as 0.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } state_t;

   localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   state_t     r_State;
   logic       r_Rx_Meta;
   logic       r_Rx;
   logic [7:0] r_Clk_Count;
   logic [2:0] r_Bit_Index;
   logic [7:0] r_Shift;
   logic [7:0] r_Rx_Byte;
   logic       r_Rx_DV;
   logic       r_Frame_Err;
   logic       r_Active;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         r_Rx_Meta   <= 1'b1;
         r_Rx        <= 1'b1;
         r_State     <= IDLE;
         r_Clk_Count <= 8'd0;
         r_Bit_Index <= 3'd0;
         r_Shift     <= 8'h00;
         r_Rx_Byte   <= 8'h00;
         r_Rx_DV     <= 1'b0;
         r_Frame_Err <= 1'b0;
         r_Active    <= 1'b0;
      end else begin
         r_Rx_Meta   <= i_Rx_Serial;
         r_Rx        <= r_Rx_Meta;
         r_Rx_DV     <= 1'b0;
         r_Frame_Err <= 1'b0;
         case (r_State)
            IDLE: begin
               r_Clk_Count <= 8'd0;
               r_Bit_Index <= 3'd0;
               if (!r_Rx) r_State <= START;
            end
            START: begin
               if (r_Clk_Count == HALF) begin
                  r_Clk_Count <= 8'd0;
                  if (!r_Rx) begin
                     r_Active <= 1'b1;
                     r_State  <= DATA;
                  end else begin
                     r_State <= IDLE;
                  end
               end else begin
                  r_Clk_Count <= r_Clk_Count + 8'd1;
               end
            end
            DATA: begin
               if (r_Clk_Count == LAST) begin
                  r_Clk_Count          <= 8'd0;
                  r_Shift[r_Bit_Index] <= r_Rx;
                  if (r_Bit_Index == 3'd7) begin
                     r_Bit_Index <= 3'd0;
                     r_State     <= STOP;
                  end else begin
                     r_Bit_Index <= r_Bit_Index + 3'd1;
                  end
               end else begin
                  r_Clk_Count <= r_Clk_Count + 8'd1;
               end
            end
            STOP: begin
               if (r_Clk_Count == LAST) begin
                  r_Clk_Count <= 8'd0;
                  r_Active    <= 1'b0;
                  if (r_Rx) begin
                     r_Rx_Byte <= r_Shift;
                     r_Rx_DV   <= 1'b1;
                  end else begin
                     r_Frame_Err <= 1'b1;
                  end
                  r_State <= CLEANUP;
               end else begin
                  r_Clk_Count <= r_Clk_Count + 8'd1;
               end
            end
            CLEANUP: begin
               // A line held low after a bad stop bit is a break, not a new start.
               if (r_Rx) r_State <= IDLE;
            end
            default: begin
               r_State     <= IDLE;
               r_Clk_Count <= 8'd0;
               r_Bit_Index <= 3'd0;
               r_Active    <= 1'b0;
            end
         endcase
      end
   end

   assign o_Rx_DV        = r_Rx_DV;
   assign o_Rx_Byte      = r_Rx_Byte;
   assign o_Rx_Frame_Err = r_Frame_Err;
   assign o_Rx_Active    = r_Active;

endmodule

// File: tb/tb_uart_rx_basic.sv
// Directed bench for uart_rx_basic at CLKS_PER_BIT=8, line driven by a
// bit-accurate 8N1 transmitter task.
module tb_uart_rx_basic;
  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       rx_active;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_cnt   = 0;
  int err_cnt  = 0;
  bit active_seen = 0;
  logic [7:0] exp_q[$];
  int dv0, err0;

  uart_rx_basic #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (rx_dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (rx_err),
    .o_Rx_Active    (rx_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits[0] is the start bit; sends the first n bits of the frame
  task automatic drive_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      wait_clks(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    drive_bits({stop_bit, data, 1'b0}, 10);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rx_active) active_seen = 1'b1;
    if (rx_dv) begin
      dv_cnt++;
      if (exp_q.size() > 0) check("dv_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
    end
    if (rx_err) err_cnt++;
    if (rx_dv || rx_err) check("dv_err_exclusive", {31'd0, rx_dv & rx_err}, 32'd0);
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b0;
    wait_clks(5);
    check("rst_dv",     {31'd0, rx_dv},     32'd0);
    check("rst_byte",   {24'd0, rx_byte},   32'd0);
    check("rst_err",    {31'd0, rx_err},    32'd0);
    check("rst_active", {31'd0, rx_active}, 32'd0);
    check("rst_state",  32'(dut.r_State),   32'd0);
    rx = 1'b1;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(20);
    check("idle_no_dv",  dv_cnt,  0);
    check("idle_no_err", err_cnt, 0);

    // single good frame
    dv0 = dv_cnt; err0 = err_cnt; active_seen = 0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_clks(10);
    check("a5_dv_count",  dv_cnt - dv0, 1);
    check("a5_byte",      {24'd0, rx_byte}, 32'hA5);
    check("a5_active",    {31'd0, active_seen}, 32'd1);
    check("a5_active_end",{31'd0, rx_active}, 32'd0);
    check("a5_no_err",    err_cnt - err0, 0);
    check("a5_q_empty",   exp_q.size(), 0);

    // back-to-back frames, no idle gap
    dv0 = dv_cnt; err0 = err_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_clks(10);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    check("b2b_byte",     {24'd0, rx_byte}, 32'hFF);
    check("b2b_q_empty",  exp_q.size(), 0);
    check("b2b_no_err",   err_cnt - err0, 0);

    // 3-clock low glitch on idle line
    dv0 = dv_cnt; err0 = err_cnt; active_seen = 0;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(20);
    check("glitch_no_dv",  dv_cnt - dv0, 0);
    check("glitch_no_err", err_cnt - err0, 0);
    check("glitch_active", {31'd0, active_seen}, 32'd0);
    check("glitch_state",  32'(dut.r_State), 32'd0);

    // framing error followed by a long break, then a good frame
    dv0 = dv_cnt; err0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clks(40);
    rx = 1'b1;
    wait_clks(20);
    check("ferr_err_count", err_cnt - err0, 1);
    check("ferr_no_dv",     dv_cnt - dv0, 0);
    check("ferr_byte_kept", {24'd0, rx_byte}, 32'hFF);
    dv0 = dv_cnt; err0 = err_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    wait_clks(10);
    check("after_ferr_dv",   dv_cnt - dv0, 1);
    check("after_ferr_byte", {24'd0, rx_byte}, 32'h5A);
    check("after_ferr_q",    exp_q.size(), 0);

    // reset during data bit 4 of 0x81, then a clean 0x42
    dv0 = dv_cnt; err0 = err_cnt;
    drive_bits({1'b1, 8'h81, 1'b0}, 5);
    rx = 1'b0;
    wait_clks(3);
    check("midrst_active_before", {31'd0, rx_active}, 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(3);
    check("midrst_active_in_rst", {31'd0, rx_active}, 32'd0);
    rst_n = 1'b1;
    wait_clks(30);
    check("midrst_no_dv",  dv_cnt - dv0, 0);
    check("midrst_no_err", err_cnt - err0, 0);
    check("midrst_byte",   {24'd0, rx_byte}, 32'd0);
    check("midrst_state",  32'(dut.r_State), 32'd0);
    dv0 = dv_cnt;
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    wait_clks(10);
    check("post_rst_dv",   dv_cnt - dv0, 1);
    check("post_rst_byte", {24'd0, rx_byte}, 32'h42);
    check("post_rst_q",    exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
